// File: rtl/tcp_rx_slow_ctrl.sv
// Control FSM for the TCP RX slow path: sequences one packet at a time through
// CAM lookup, optional flowid allocation, flow-state read/calc and writeback.
module tcp_rx_slow_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             src_rx_hdr_val,
  input  logic [7:0]       rx_tcp_flags,
  output logic             src_rx_hdr_rdy,
  output logic             ctrl_datap_save_input,
  output logic             store_flowid_cam,
  output logic             store_flowid_manager,
  output logic             ctrl_datap_save_flow_state,
  output logic             ctrl_datap_save_calcs,
  output logic             read_flow_cam_val,
  input  logic             read_flow_cam_resp_val,
  input  logic             read_flow_cam_hit,
  output logic             flowid_manager_req,
  input  logic             flowid_manager_avail,
  output logic             flow_state_rd_req_val,
  input  logic             flow_state_rd_resp_val,
  output logic             flow_state_wr_req_val,
  input  logic             flow_state_wr_req_rdy,
  output logic             rx_sched_update_val,
  input  logic             rx_sched_update_rdy,
  output logic             tcp_rx_dst_hdr_val,
  input  logic             tcp_rx_dst_rdy,
  output logic             new_flow_val,
  input  logic             new_flow_rdy,
  output logic             app_new_flow_notif_val,
  input  logic             app_new_flow_notif_rdy,
  output logic             slow_path_send_pkt_enqueue_val,
  input  logic             slow_path_send_pkt_enqueue_rdy,
  output logic [CNT_W-1:0] pkt_drop_cnt,
  output logic [CNT_W-1:0] new_flow_cnt
);

  typedef enum logic [3:0] {
    S_READY, S_CAM_REQ, S_CAM_WAIT, S_ALLOC, S_ST_RD,
    S_ST_WAIT, S_CALC, S_WB, S_NF_OUT, S_DROP
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       done_q, done_d;
  logic [7:0]       flags_q, flags_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] nf_cnt_q, nf_cnt_d;

  logic       syn_flag, ack_flag, in_multi;
  logic [2:0] multi_rdy, multi_val, multi_fire;
  logic       all_done;

  // Flags are latched at accept so the classification does not depend on the source holding them.
  assign syn_flag = flags_q[1];
  assign ack_flag = flags_q[4];

  // WB and NF_OUT share the three done bits; only the responder set differs.
  assign in_multi   = (state_q == S_WB) || (state_q == S_NF_OUT);
  assign multi_rdy  = (state_q == S_WB)
                    ? {tcp_rx_dst_rdy, rx_sched_update_rdy, flow_state_wr_req_rdy}
                    : {slow_path_send_pkt_enqueue_rdy, app_new_flow_notif_rdy, new_flow_rdy};
  assign multi_val  = (in_multi && !rst) ? ~done_q : 3'b000;
  assign multi_fire = multi_val & multi_rdy;
  assign all_done   = &(done_q | multi_fire);

  assign pkt_drop_cnt = drop_cnt_q;
  assign new_flow_cnt = nf_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_READY;
      done_q     <= 3'b000;
      flags_q    <= 8'h00;
      drop_cnt_q <= '0;
      nf_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      flags_q    <= flags_d;
      drop_cnt_q <= drop_cnt_d;
      nf_cnt_q   <= nf_cnt_d;
    end
  end

  always_comb begin
    state_d                        = state_q;
    done_d                         = done_q;
    flags_d                        = flags_q;
    drop_cnt_d                     = drop_cnt_q;
    nf_cnt_d                       = nf_cnt_q;
    src_rx_hdr_rdy                 = 1'b0;
    ctrl_datap_save_input          = 1'b0;
    store_flowid_cam               = 1'b0;
    store_flowid_manager           = 1'b0;
    ctrl_datap_save_flow_state     = 1'b0;
    ctrl_datap_save_calcs          = 1'b0;
    read_flow_cam_val              = 1'b0;
    flowid_manager_req             = 1'b0;
    flow_state_rd_req_val          = 1'b0;
    flow_state_wr_req_val          = 1'b0;
    rx_sched_update_val            = 1'b0;
    tcp_rx_dst_hdr_val             = 1'b0;
    new_flow_val                   = 1'b0;
    app_new_flow_notif_val         = 1'b0;
    slow_path_send_pkt_enqueue_val = 1'b0;

    unique case (state_q)
      S_READY: begin
        src_rx_hdr_rdy = 1'b1;
        if (src_rx_hdr_val) begin
          ctrl_datap_save_input = 1'b1;
          flags_d               = rx_tcp_flags;
          state_d               = S_CAM_REQ;
        end
      end
      S_CAM_REQ: begin
        read_flow_cam_val = 1'b1;
        state_d           = S_CAM_WAIT;
      end
      S_CAM_WAIT: begin
        if (read_flow_cam_resp_val) begin
          if (read_flow_cam_hit && !syn_flag) begin
            store_flowid_cam = 1'b1;
            state_d          = S_ST_RD;
          end else if (!read_flow_cam_hit && syn_flag && !ack_flag) begin
            state_d = S_ALLOC;
          end else begin
            state_d = S_DROP;
          end
        end
      end
      S_ALLOC: begin
        flowid_manager_req = 1'b1;
        if (flowid_manager_avail) begin
          store_flowid_manager = 1'b1;
          done_d               = 3'b000;
          state_d              = S_NF_OUT;
        end else begin
          state_d = S_DROP;
        end
      end
      S_ST_RD: begin
        flow_state_rd_req_val = 1'b1;
        state_d               = S_ST_WAIT;
      end
      S_ST_WAIT: begin
        if (flow_state_rd_resp_val) begin
          ctrl_datap_save_flow_state = 1'b1;
          state_d                    = S_CALC;
        end
      end
      S_CALC: begin
        ctrl_datap_save_calcs = 1'b1;
        done_d                = 3'b000;
        state_d               = S_WB;
      end
      S_WB: begin
        flow_state_wr_req_val = multi_val[0];
        rx_sched_update_val   = multi_val[1];
        tcp_rx_dst_hdr_val    = multi_val[2];
        done_d                = done_q | multi_fire;
        if (all_done) state_d = S_READY;
      end
      S_NF_OUT: begin
        new_flow_val                   = multi_val[0];
        app_new_flow_notif_val         = multi_val[1];
        slow_path_send_pkt_enqueue_val = multi_val[2];
        done_d                         = done_q | multi_fire;
        if (all_done) begin
          if (!(&nf_cnt_q)) nf_cnt_d = nf_cnt_q + CNT_W'(1);
          state_d = S_READY;
        end
      end
      S_DROP: begin
        if (!(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
        state_d = S_READY;
      end
      default: state_d = S_READY;
    endcase

    // Nothing handshakes or strobes while reset is held, whatever the current state.
    if (rst) begin
      src_rx_hdr_rdy                 = 1'b0;
      ctrl_datap_save_input          = 1'b0;
      store_flowid_cam               = 1'b0;
      store_flowid_manager           = 1'b0;
      ctrl_datap_save_flow_state     = 1'b0;
      ctrl_datap_save_calcs          = 1'b0;
      read_flow_cam_val              = 1'b0;
      flowid_manager_req             = 1'b0;
      flow_state_rd_req_val          = 1'b0;
    end
  end

endmodule
